// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: buffer-id width, default frame geometry,
// pixel width and the writer FSM state encoding. The frame reader and the
// BufferController reuse the same defaults.
package fb_pkg;

   localparam int unsigned BUF_ID_W          = 2;
   localparam int unsigned PIX_W             = 16;
   localparam int unsigned FRAME_PIXELS_DEF  = 307200;   // 640x480
   localparam int unsigned BUFFER_STRIDE_DEF = 524288;   // words between buffer bases
   localparam int unsigned ADDR_W_DEF        = 21;
   localparam int unsigned FIFO_DEPTH_DEF    = 16;

   typedef enum logic [2:0] {
      WR_REQ_BUF  = 3'd0,
      WR_REL_BUF  = 3'd1,
      WR_WAIT_FRM = 3'd2,
      WR_STREAM   = 3'd3,
      WR_FLUSH    = 3'd4,
      WR_FINAL    = 3'd5
   } wr_state_e;

endpackage

// File: rtl/frame_buffer_writer_if.sv
// SDRAM write-port bus between the frame buffer writer (master) and the
// SDRAM controller (slave).
//   mem_wr_valid  master->slave  word valid
//   mem_wr_ready  slave->master  word accepted when valid & ready
//   mem_wr_addr   master->slave  word address
//   mem_wr_data   master->slave  RGB565 word
interface frame_buffer_writer_if #(
   parameter int unsigned ADDR_W = fb_pkg::ADDR_W_DEF
);
   logic                     mem_wr_valid;
   logic                     mem_wr_ready;
   logic [ADDR_W-1:0]        mem_wr_addr;
   logic [fb_pkg::PIX_W-1:0] mem_wr_data;

   modport master (output mem_wr_valid, output mem_wr_addr, output mem_wr_data,
                   input  mem_wr_ready);
   modport slave  (input  mem_wr_valid, input  mem_wr_addr, input  mem_wr_data,
                   output mem_wr_ready);
endinterface

// File: rtl/fb_pixel_fifo.sv
// Synchronous pixel FIFO; each entry carries {pixel index, pixel data} so the
// write address survives dropped pixels.
//   clk, reset   clock, synchronous active-high reset
//   push, wdata  write request / entry (ignored when full unless popping)
//   pop          read request (ignored when empty)
//   rdata        head entry, valid while !empty
//   full, empty  occupancy flags
module fb_pixel_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push, do_pop;

   // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign rdata = mem_q[rd_ptr_q];

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/frame_buffer_writer.sv
// Write-side client of the BufferController: claims a free frame buffer,
// streams one camera frame into that buffer's SDRAM region through a small
// FIFO, then pulses finalize_wr so the buffer becomes readable.
//   clk, reset                 fb_clk, synchronous active-high reset
//   frame_start                1-cycle start-of-frame pulse
//   pixel_valid, pixel_data    camera pixel stream (no backpressure)
//   write_rq_rdy               buffer request to BufferController
//   buffer_id_valid, buffer_id buffer grant
//   finalize_wr                1-cycle pulse, buffer fully written
//   overflow                   sticky, pixel dropped on full FIFO
//   frame_error                1-cycle pulse, frame truncated by early frame_start
//   mem                        SDRAM write port (master)
module frame_buffer_writer
   import fb_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS  = FRAME_PIXELS_DEF,
   parameter int unsigned BUFFER_STRIDE = BUFFER_STRIDE_DEF,
   parameter int unsigned ADDR_W        = ADDR_W_DEF,
   parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_start,
   input  logic                pixel_valid,
   input  logic [PIX_W-1:0]    pixel_data,
   output logic                write_rq_rdy,
   input  logic                buffer_id_valid,
   input  logic [BUF_ID_W-1:0] buffer_id,
   output logic                finalize_wr,
   output logic                overflow,
   output logic                frame_error,
   frame_buffer_writer_if.master mem
);
   localparam int unsigned CNT_W     = $clog2(FRAME_PIXELS + 1);
   localparam int unsigned STRIDE_SH = $clog2(BUFFER_STRIDE);
   localparam int unsigned ENTRY_W   = CNT_W + PIX_W;

   wr_state_e           state_q, state_d;
   logic [BUF_ID_W-1:0] buf_id_q, buf_id_d;
   logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
   logic                rq_rdy_q, rq_rdy_d;
   logic                finalize_q, finalize_d;
   logic                overflow_q, overflow_d;
   logic                frame_error_q, frame_error_d;

   logic                accept_c, pop_c, frame_done_c;
   logic                fifo_full, fifo_empty;
   logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
   logic [CNT_W-1:0]    rd_index;
   logic [PIX_W-1:0]    rd_pixel;

   assign fifo_wdata = {pix_cnt_q, pixel_data};
   assign rd_index   = fifo_rdata[ENTRY_W-1 -: CNT_W];
   assign rd_pixel   = fifo_rdata[PIX_W-1:0];
   assign pop_c      = !fifo_empty && mem.mem_wr_ready;

   fb_pixel_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept_c),
      .pop   (pop_c),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Drain side: the address comes from the stored pixel index, so a dropped
   // pixel leaves a hole in the address sequence rather than shifting it.
   assign mem.mem_wr_valid = !fifo_empty;
   assign mem.mem_wr_addr  = fifo_empty ? '0
                           : (ADDR_W'(buf_id_q) << STRIDE_SH) + ADDR_W'(rd_index);
   assign mem.mem_wr_data  = fifo_empty ? '0 : rd_pixel;

   assign write_rq_rdy = rq_rdy_q;
   assign finalize_wr  = finalize_q;
   assign overflow     = overflow_q;
   assign frame_error  = frame_error_q;

   // Next-state and output decode
   always_comb begin
      state_d       = state_q;
      buf_id_d      = buf_id_q;
      pix_cnt_d     = pix_cnt_q;
      overflow_d    = overflow_q;
      frame_error_d = 1'b0;
      accept_c      = 1'b0;
      frame_done_c  = (pix_cnt_q == CNT_W'(FRAME_PIXELS));

      unique case (state_q)
         WR_REQ_BUF: begin
            if (buffer_id_valid) begin
               buf_id_d = buffer_id;
               state_d  = WR_REL_BUF;
            end
         end
         WR_REL_BUF: begin
            if (!buffer_id_valid) state_d = WR_WAIT_FRM;
         end
         WR_WAIT_FRM: begin
            if (frame_start) begin
               pix_cnt_d = '0;
               state_d   = WR_STREAM;
            end
         end
         WR_STREAM: begin
            if (frame_done_c) begin
               state_d = WR_FLUSH;
            end else if (frame_start) begin
               // Early start truncates this frame; the new frame is not captured.
               state_d       = WR_FLUSH;
               frame_error_d = 1'b1;
            end else if (pixel_valid) begin
               accept_c  = 1'b1;
               pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
         end
         WR_FLUSH: begin
            if (fifo_empty) state_d = WR_FINAL;
         end
         WR_FINAL: begin
            state_d = WR_REQ_BUF;
         end
         default: begin
            state_d = WR_REQ_BUF;
         end
      endcase

      // Counted pixel that found no free slot is lost.
      if (accept_c && fifo_full && !pop_c) overflow_d = 1'b1;

      rq_rdy_d   = (state_d == WR_REQ_BUF);
      finalize_d = (state_d == WR_FINAL);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= WR_REQ_BUF;
         buf_id_q      <= '0;
         pix_cnt_q     <= '0;
         rq_rdy_q      <= 1'b0;
         finalize_q    <= 1'b0;
         overflow_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         buf_id_q      <= buf_id_d;
         pix_cnt_q     <= pix_cnt_d;
         rq_rdy_q      <= rq_rdy_d;
         finalize_q    <= finalize_d;
         overflow_q    <= overflow_d;
         frame_error_q <= frame_error_d;
      end
   end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer with a reduced frame (64 pixels, stride 128).
// A BufferController model grants ids 1,2,0 in rotation; stimulus pushes the
// expected {addr,data} of every sent pixel, and a negedge monitor pops and
// compares accepted SDRAM words. Pixel data = {frame tag, pixel index}.
module tb_frame_buffer_writer;
   import fb_pkg::*;

   localparam int unsigned FP     = 64;
   localparam int unsigned STRIDE = 128;
   localparam int unsigned AW     = 9;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [PIX_W-1:0] data;
   } sb_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                frame_start;
   logic                pixel_valid;
   logic [PIX_W-1:0]    pixel_data;
   logic                write_rq_rdy;
   logic                buffer_id_valid;
   logic [BUF_ID_W-1:0] buffer_id;
   logic                finalize_wr;
   logic                overflow;
   logic                frame_error;

   frame_buffer_writer_if #(.ADDR_W(AW)) mem_if ();

   frame_buffer_writer #(
      .FRAME_PIXELS  (FP),
      .BUFFER_STRIDE (STRIDE),
      .ADDR_W        (AW),
      .FIFO_DEPTH    (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .frame_start     (frame_start),
      .pixel_valid     (pixel_valid),
      .pixel_data      (pixel_data),
      .write_rq_rdy    (write_rq_rdy),
      .buffer_id_valid (buffer_id_valid),
      .buffer_id       (buffer_id),
      .finalize_wr     (finalize_wr),
      .overflow        (overflow),
      .frame_error     (frame_error),
      .mem             (mem_if)
   );

   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_fail   = 0;
   sb_t sb_q[$];
   int  fin_cnt = 0, err_cnt = 0, err_exp = 0, skipped = 0;
   int  grant_cnt = 0, grants_used = 0, frame_tag = 0;
   logic [BUF_ID_W-1:0] granted_id = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // BufferController model: grant on request, drop grant once request falls.
   initial begin
      logic [BUF_ID_W-1:0] ids [3];
      int seq;
      ids[0] = 2'd1; ids[1] = 2'd2; ids[2] = 2'd0;
      seq = 0;
      buffer_id_valid = 1'b0;
      buffer_id       = '0;
      forever begin
         @(posedge clk); #2;
         if (reset) begin
            buffer_id_valid = 1'b0;
         end else if (buffer_id_valid) begin
            chk("rq_rdy_low_after_grant", 32'(write_rq_rdy), 0);
            buffer_id_valid = 1'b0;
            granted_id      = buffer_id;
            grant_cnt++;
            seq = (seq + 1) % 3;
         end else if (write_rq_rdy) begin
            buffer_id_valid = 1'b1;
            buffer_id       = ids[seq];
         end
      end
   end

   // Output monitor and scoreboard
   logic            fin_prev = 1'b0, prev_stall = 1'b0;
   logic [AW-1:0]    prev_addr;
   logic [PIX_W-1:0] prev_data;
   always @(negedge clk) begin
      sb_t e;
      bit  found;
      if (reset) begin
         fin_prev   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (finalize_wr) begin
            fin_cnt++;
            chk("finalize_single_cycle", 32'(fin_prev), 0);
            chk("finalize_after_last_word", 32'(sb_q.size()), 0);
         end
         fin_prev = finalize_wr;
         if (frame_error) err_cnt++;
         if (prev_stall) begin
            chk("stall_valid_held", 32'(mem_if.mem_wr_valid), 1);
            chk("stall_addr_held", 32'(mem_if.mem_wr_addr), 32'(prev_addr));
            chk("stall_data_held", 32'(mem_if.mem_wr_data), 32'(prev_data));
         end
         prev_stall = mem_if.mem_wr_valid && !mem_if.mem_wr_ready;
         prev_addr  = mem_if.mem_wr_addr;
         prev_data  = mem_if.mem_wr_data;
         if (mem_if.mem_wr_valid && mem_if.mem_wr_ready) begin
            // Entries skipped over belong to pixels dropped on overflow.
            found = 1'b0;
            e     = '0;
            while (sb_q.size() > 0 && !found) begin
               e = sb_q.pop_front();
               if (e.addr == mem_if.mem_wr_addr) found = 1'b1;
               else skipped++;
            end
            chk("word_addr_expected", 32'(found), 1);
            if (found) chk("word_data", 32'(mem_if.mem_wr_data), 32'(e.data));
         end
      end
   end

   function automatic logic ready_for(input int mode, input int cyc, input int k);
      case (mode)
         1:       return logic'($urandom_range(0, 1)) || (cyc % 3 == 0);
         2:       return !(k >= 10 && k <= 49);
         default: return 1'b1;
      endcase
   endfunction

   task automatic wait_grant(output logic [BUF_ID_W-1:0] id);
      int c = 0;
      while (grant_cnt == grants_used && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      chk("grant_received", 32'(grant_cnt != grants_used), 1);
      grants_used = grant_cnt;
      id          = granted_id;
      @(posedge clk); #1;
   endtask

   // One frame: npix pixel slots; at slot trunc_at a frame_start is sent instead
   // of a pixel, and later pixels must be ignored.
   task automatic run_frame(input int npix, input int trunc_at, input int mode,
                            input int gap, input int exp_drops, input logic exp_ovf);
      logic [BUF_ID_W-1:0] id;
      logic [AW-1:0]       base;
      int                  fin0, skip0, cyc;
      sb_t                 e;
      wait_grant(id);
      base  = AW'(id) * AW'(STRIDE);
      fin0  = fin_cnt;
      skip0 = skipped;
      cyc   = 0;
      frame_tag++;
      if (trunc_at < npix) err_exp++;
      frame_start = 1'b1; pixel_valid = 1'b0; mem_if.mem_wr_ready = 1'b1;
      for (int k = 0; k < npix; k++) begin
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            frame_start = 1'b0; pixel_valid = 1'b0;
            mem_if.mem_wr_ready = ready_for(mode, cyc++, -1);
         end
         @(posedge clk); #1;
         frame_start = 1'b0;
         mem_if.mem_wr_ready = ready_for(mode, cyc++, k);
         if (k == trunc_at) begin
            frame_start = 1'b1;
            pixel_valid = 1'b0;
         end else begin
            pixel_valid = 1'b1;
            pixel_data  = {8'(frame_tag), 8'(k)};
            if (k < trunc_at) begin
               e.addr = base + AW'(k);
               e.data = pixel_data;
               sb_q.push_back(e);
            end
         end
      end
      for (int c = 0; c < 3000 && fin_cnt == fin0; c++) begin
         @(posedge clk); #1;
         frame_start = 1'b0; pixel_valid = 1'b0;
         mem_if.mem_wr_ready = ready_for(mode, cyc++, -1);
      end
      repeat (3) begin
         @(posedge clk); #1;
         frame_start = 1'b0; pixel_valid = 1'b0; mem_if.mem_wr_ready = 1'b1;
      end
      chk("finalize_count", 32'(fin_cnt - fin0), 1);
      chk("dropped_pixels", 32'(skipped - skip0), 32'(exp_drops));
      chk("overflow_flag", 32'(overflow), 32'(exp_ovf));
      chk("frame_error_count", 32'(err_cnt), 32'(err_exp));
      chk("scoreboard_drained", 32'(sb_q.size()), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_write_rq_rdy"}, 32'(write_rq_rdy), 0);
      chk({tag, "_finalize_wr"},  32'(finalize_wr), 0);
      chk({tag, "_mem_wr_valid"}, 32'(mem_if.mem_wr_valid), 0);
      chk({tag, "_mem_wr_addr"},  32'(mem_if.mem_wr_addr), 0);
      chk({tag, "_mem_wr_data"},  32'(mem_if.mem_wr_data), 0);
      chk({tag, "_overflow"},     32'(overflow), 0);
      chk({tag, "_frame_error"},  32'(frame_error), 0);
   endtask

   // Reset while words sit in the FIFO: frame abandoned, no finalize.
   task automatic reset_mid_stream();
      logic [BUF_ID_W-1:0] id;
      int fin0;
      wait_grant(id);
      fin0 = fin_cnt;
      frame_tag++;
      frame_start = 1'b1; pixel_valid = 1'b0; mem_if.mem_wr_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         frame_start = 1'b0;
         pixel_valid = 1'b1;
         pixel_data  = {8'(frame_tag), 8'(k)};
      end
      @(posedge clk); #1;
      pixel_valid = 1'b0; reset = 1'b1; mem_if.mem_wr_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_idle_outputs("mid_reset");
      @(posedge clk); #1;
      chk("rerequest_after_reset", 32'(write_rq_rdy), 1);
      repeat (5) begin @(posedge clk); #1; end
      chk("no_finalize_after_reset", 32'(fin_cnt), 32'(fin0));
   endtask

   initial begin
      reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; pixel_data = '0;
      mem_if.mem_wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;

      run_frame(FP, FP, 0, 0, 0, 1'b0);   // buffer 1, base 128
      run_frame(FP, FP, 0, 0, 0, 1'b0);   // buffer 2, base 256
      run_frame(FP, FP, 0, 0, 0, 1'b0);   // buffer 0, base 0
      run_frame(FP, FP, 1, 3, 0, 1'b0);   // random ready stalls
      run_frame(FP, FP, 2, 0, 25, 1'b1);  // 40-cycle stall: pixels 25..49 dropped
      run_frame(30, 20, 0, 0, 0, 1'b1);   // truncated after 20 pixels
      run_frame(FP, FP, 0, 0, 0, 1'b1);   // next frame captured normally
      reset_mid_stream();
      run_frame(FP, FP, 0, 0, 0, 1'b0);   // recovery after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
